fft_result_streamer: RTL and testbench

- Sits directly downstream of the FFT core and consumes its output bins.
- Captures each bin presented on x0_re_i/x0_im_i while fft_ready_i is high and buffers it in an internal FIFO.
- Re-emits the bins as a valid/ready stream with bin index and end-of-frame marker, toward the downlink/DMA.
- Back-pressures the FFT through dl_busy_o and flags overflow and short-frame errors.

---
 rtl/fft_result_streamer.sv | 143 ++++++++++++++
 tb/tb_fft_result_streamer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_streamer.sv
// fft_result_streamer: buffers FFT output bins in a first-word-fall-through
// FIFO and re-emits them as a valid/ready stream tagged with bin index and
// end-of-frame. Raises dl_busy_o to throttle the FFT and keeps sticky
// overflow / short-frame error flags.
module fft_result_streamer #(
  parameter int N           = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 64,
  parameter int BUSY_MARGIN = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      fft_ready_i,
  input  logic                      fft_done_i,
  input  logic [DATA_WIDTH-1:0]     x0_re_i,
  input  logic [DATA_WIDTH-1:0]     x0_im_i,
  output logic                      dl_busy_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [2*DATA_WIDTH-1:0]   m_data_o,
  output logic [$clog2(N)-1:0]      m_index_o,
  output logic                      m_last_o,
  output logic [15:0]               frame_cnt_o,
  output logic                      overflow_o,
  output logic                      frame_err_o
);

  localparam int IDX_W  = $clog2(N);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ENT_W  = 2 * DATA_WIDTH + IDX_W + 1;
  localparam int THRESH = FIFO_DEPTH - BUSY_MARGIN;

  // Entry layout: {re, im, index, last}
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;

  logic             head_valid;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] head_entry;

  // Head of the FIFO is read combinationally so the first word falls through
  assign head_entry = fifo_mem[rd_ptr_q];
  assign head_valid = (level_q != '0);
  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop        = head_valid && m_ready_i;
  // A push into a full FIFO still fits when the head leaves on the same edge
  assign push_ok    = fft_ready_i && (!full || pop);
  assign wr_entry   = {x0_re_i, x0_im_i, wr_idx_q, (wr_idx_q == IDX_W'(N - 1))};

  // Next-state computation for pointers, level, index and status flags
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Bin index advances even for a dropped bin so the frame stays aligned
    if (fft_done_i && ((wr_idx_q != '0) || fft_ready_i)) begin
      frame_err_d = 1'b1;
      wr_idx_d    = '0;
    end else if (fft_ready_i) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end

    if (fft_ready_i && !push_ok) overflow_d = 1'b1;

    if (pop && head_entry[0]) frame_cnt_d = frame_cnt_q + 16'd1;

    // Registered from the next level so busy lines up with the new level
    busy_d = (level_d >= LVL_W'(THRESH));
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage array; contents are don't-care until validated by the level
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wr_entry;
  end

  // Output fields are forced to zero whenever no bin is presented
  always_comb begin
    m_valid_o = head_valid;
    m_data_o  = '0;
    m_index_o = '0;
    m_last_o  = 1'b0;
    if (head_valid) begin
      m_data_o  = head_entry[ENT_W-1 -: 2*DATA_WIDTH];
      m_index_o = head_entry[IDX_W:1];
      m_last_o  = head_entry[0];
    end
  end

  assign dl_busy_o   = busy_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed self-checking bench for fft_result_streamer (N=8, FIFO_DEPTH=16,
// BUSY_MARGIN=4). Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, well away from the next edge.
module tb_fft_result_streamer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int FD = 16;
  localparam int BM = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            fft_ready_i = 1'b0;
  logic            fft_done_i = 1'b0;
  logic [DW-1:0]   x0_re_i = '0;
  logic [DW-1:0]   x0_im_i = '0;
  logic            dl_busy_o;
  logic            m_valid_o;
  logic            m_ready_i = 1'b0;
  logic [2*DW-1:0] m_data_o;
  logic [2:0]      m_index_o;
  logic            m_last_o;
  logic [15:0]     frame_cnt_o;
  logic            overflow_o;
  logic            frame_err_o;

  int errors = 0;
  int checks = 0;

  fft_result_streamer #(
    .N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BUSY_MARGIN(BM)
  ) dut (
    .clk(clk), .rstn(rstn),
    .fft_ready_i(fft_ready_i), .fft_done_i(fft_done_i),
    .x0_re_i(x0_re_i), .x0_im_i(x0_im_i),
    .dl_busy_o(dl_busy_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_index_o(m_index_o), .m_last_o(m_last_o),
    .frame_cnt_o(frame_cnt_o), .overflow_o(overflow_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        done;
    logic [31:0] re;
    logic [31:0] im;
    logic        mr;
    logic        e_valid;
    logic [2:0]  e_idx;
    logic        e_last;
    logic [63:0] e_data;
    logic [15:0] e_fcnt;
    logic        e_ferr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic done, input logic [31:0] re,
                      input logic [31:0] im, input logic mr);
    fft_ready_i = rdy;
    fft_done_i  = done;
    x0_re_i     = re;
    x0_im_i     = im;
    m_ready_i   = mr;
    @(posedge clk);
    #1;
    fft_ready_i = 1'b0;
    fft_done_i  = 1'b0;
    m_ready_i   = 1'b0;
  endtask

  task automatic do_reset();
    fft_ready_i = 1'b0;
    fft_done_i  = 1'b0;
    m_ready_i   = 1'b0;
    rstn        = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic chk_head(input string name, input logic [63:0] data, input logic [2:0] idx,
                          input logic last);
    chk({name, "_valid"}, m_valid_o, 1'b1);
    chk({name, "_data"}, m_data_o, data);
    chk({name, "_idx"}, m_index_o, idx);
    chk({name, "_last"}, m_last_o, last);
  endtask

  initial begin
    // Streaming frame vectors: bin i = {i, -i}, consumer always ready
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, 32'(i), 32'(-i), 1'b1,
                  1'b1, 3'(i), (i == 7), {32'(i), 32'(-i)}, 16'd0, 1'b0};
    end
    // Trailing done pulse with index back at 0: no error, last bin drained
    vecs[8] = '{1'b0, 1'b1, 32'd0, 32'd0, 1'b1,
                1'b0, 3'd0, 1'b0, 64'd0, 16'd1, 1'b0};

    // ---- reset state ----
    do_reset();
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_fcnt", frame_cnt_o, 16'd0);
    chk("rst_busy", dl_busy_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_ferr", frame_err_o, 1'b0);
    chk("rst_data", m_data_o, 64'd0);

    // ---- full frame streamed through ----
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rdy, vecs[i].done, vecs[i].re, vecs[i].im, vecs[i].mr);
      $display("vec %0d: valid=%0d idx=%0d last=%0d data=%h fcnt=%0d",
               i, m_valid_o, m_index_o, m_last_o, m_data_o, frame_cnt_o);
      chk("t1_valid", m_valid_o, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk("t1_data", m_data_o, vecs[i].e_data);
        chk("t1_idx", m_index_o, vecs[i].e_idx);
        chk("t1_last", m_last_o, vecs[i].e_last);
      end
      chk("t1_fcnt", frame_cnt_o, vecs[i].e_fcnt);
      chk("t1_ferr", frame_err_o, vecs[i].e_ferr);
      chk("t1_ovf", overflow_o, 1'b0);
      chk("t1_busy", dl_busy_o, 1'b0);
    end

    // ---- busy threshold and stall stability ----
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'(100 + i), 32'(200 + i), 1'b0);
      if (i == 10) chk("t2_busy_at11", dl_busy_o, 1'b0);
      if (i == 11) chk("t2_busy_at12", dl_busy_o, 1'b1);
    end
    chk_head("t2_stall", {32'd100, 32'd200}, 3'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    $display("t2: one pop, busy=%0d head=%h", dl_busy_o, m_data_o);
    chk("t2_busy_clear", dl_busy_o, 1'b0);
    chk_head("t2_after_pop", {32'd101, 32'd201}, 3'd1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk_head("t2_hold", {32'd101, 32'd201}, 3'd1, 1'b0);
    end

    // ---- overflow then drain ----
    do_reset();
    chk("t3_rst_valid", m_valid_o, 1'b0);
    chk("t3_rst_fcnt", frame_cnt_o, 16'd0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 32'(300 + i), 32'(400 + i), 1'b0);
      if (i == 15) begin
        chk("t3_ovf_at16", overflow_o, 1'b0);
        chk("t3_busy_at16", dl_busy_o, 1'b1);
      end
    end
    chk("t3_ovf_at17", overflow_o, 1'b1);
    for (int j = 0; j < 16; j++) begin
      $display("t3 drain %0d: idx=%0d last=%0d data=%h", j, m_index_o, m_last_o, m_data_o);
      chk_head("t3_drain", {32'(300 + j), 32'(400 + j)}, 3'(j % 8), (j % 8) == 7);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("t3_empty", m_valid_o, 1'b0);
    chk("t3_fcnt", frame_cnt_o, 16'd2);
    chk("t3_ovf_sticky", overflow_o, 1'b1);

    // ---- reset mid-frame with data buffered ----
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(500 + i), 32'(510 + i), 1'b0);
    chk("t6_pre_valid", m_valid_o, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    $display("t6: async reset asserted, valid=%0d fcnt=%0d ovf=%0d", m_valid_o, frame_cnt_o, overflow_o);
    chk("t6_valid", m_valid_o, 1'b0);
    chk("t6_fcnt", frame_cnt_o, 16'd0);
    chk("t6_ovf", overflow_o, 1'b0);
    chk("t6_busy", dl_busy_o, 1'b0);
    chk("t6_data", m_data_o, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, 32'd600, 32'd700, 1'b0);
    chk_head("t6_post", {32'd600, 32'd700}, 3'd0, 1'b0);

    // ---- full FIFO, simultaneous push and pop ----
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(800 + i), 32'(900 + i), 1'b0);
    chk("t4_busy_full", dl_busy_o, 1'b1);
    step(1'b1, 1'b0, 32'd999, 32'd998, 1'b1);
    chk("t4_ovf", overflow_o, 1'b0);
    chk("t4_busy", dl_busy_o, 1'b1);
    chk_head("t4_head", {32'd801, 32'd901}, 3'd1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      $display("t4 drain %0d: idx=%0d data=%h", j, m_index_o, m_data_o);
      if (j < 15) chk_head("t4_drain", {32'(801 + j), 32'(901 + j)}, 3'((j + 1) % 8), ((j + 1) % 8) == 7);
      else        chk_head("t4_newlast", {32'd999, 32'd998}, 3'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("t4_empty", m_valid_o, 1'b0);
    chk("t4_fcnt", frame_cnt_o, 16'd2);
    chk("t4_ovf_end", overflow_o, 1'b0);

    // ---- short frame ----
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(10 + i), 32'(20 + i), 1'b0);
    chk("t5_ferr_pre", frame_err_o, 1'b0);
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    $display("t5: done after 5 bins, ferr=%0d", frame_err_o);
    chk("t5_ferr", frame_err_o, 1'b1);
    step(1'b1, 1'b0, 32'd55, 32'd66, 1'b0);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk_head("t5_next", {32'd55, 32'd66}, 3'd0, 1'b0);

    // ---- done coinciding with a push at index 0 ----
    do_reset();
    step(1'b1, 1'b1, 32'd77, 32'd88, 1'b0);
    $display("t7: done with push, ferr=%0d idx=%0d", frame_err_o, m_index_o);
    chk("t7_ferr", frame_err_o, 1'b1);
    chk_head("t7_bin", {32'd77, 32'd88}, 3'd0, 1'b0);
    step(1'b1, 1'b0, 32'd78, 32'd89, 1'b1);
    chk_head("t7_next", {32'd78, 32'd89}, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
